// File: rtl/alu_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter_pkg
// Description : Shared opcode constants, default widths and FSM state
//               encoding for the shared logic-unit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_share_arbiter_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_OP_W   = 3;
    localparam int DEFAULT_CNT_W  = 16;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin grant. The requester that did not win
//               the last grant is preferred when both are valid.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_valid0,
    input  logic i_valid1,
    output logic o_ready0,
    output logic o_ready1
);

    // Resets to 1 so requester 0 wins the first contention.
    logic r_lastGrant;

    assign o_ready0 = i_enable & (~i_valid1 |  r_lastGrant);
    assign o_ready1 = i_enable & (~i_valid0 | ~r_lastGrant);

    // Remember which requester completed the most recent handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lastGrant <= 1'b1;
        end else if (i_valid1 && o_ready1) begin
            r_lastGrant <= 1'b1;
        end else if (i_valid0 && o_ready0) begin
            r_lastGrant <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Shares one combinational 32-bit logic unit between two
//               requesters, one operation in flight, with a registered and
//               tagged valid/ready response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int OP_W   = DEFAULT_OP_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);

    state_t              r_state;
    logic [OP_W-1:0]     r_op;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_id;
    logic                w_enable;
    logic                w_hs0;
    logic                w_hs1;
    logic [DATA_W-1:0]   w_result;
    logic                w_err;

    // Readys are held low while reset is asserted as well as outside IDLE.
    assign w_enable = (r_state == IDLE) && !rst;
    assign w_hs0    = req0_valid & req0_ready;
    assign w_hs1    = req1_valid & req1_ready;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_enable (w_enable),
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .o_ready0 (req0_ready),
        .o_ready1 (req1_ready)
    );

    // Opcode-select mux over the latched operands; unused opcodes flag an error.
    always_comb begin
        w_result = '0;
        w_err    = 1'b0;
        case (r_op)
            OP_ADD:  w_result = r_a + r_b;
            OP_SUB:  w_result = r_a - r_b;
            OP_AND:  w_result = r_a & r_b;
            OP_OR:   w_result = r_a | r_b;
            OP_XOR:  w_result = r_a ^ r_b;
            OP_XNOR: w_result = ~(r_a ^ r_b);
            default: w_err    = 1'b1;
        endcase
    end

    // Control FSM with registered response, busy flag and completion counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_id      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            ops_done  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs0) begin
                        r_op    <= req0_op;
                        r_a     <= req0_a;
                        r_b     <= req0_b;
                        r_id    <= 1'b0;
                        r_state <= EXEC;
                        busy    <= 1'b1;
                    end else if (w_hs1) begin
                        r_op    <= req1_op;
                        r_a     <= req1_a;
                        r_b     <= req1_b;
                        r_id    <= 1'b1;
                        r_state <= EXEC;
                        busy    <= 1'b1;
                    end
                end
                EXEC: begin
                    rsp_data  <= w_result;
                    rsp_err   <= w_err;
                    rsp_id    <= r_id;
                    rsp_valid <= 1'b1;
                    r_state   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + {{(CNT_W-1){1'b0}}, 1'b1};
                        r_state   <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    r_state   <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Directed self-checking bench for alu_share_arbiter. The
//               counter is built narrow (4 bits) so its wrap is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                req0_valid = 1'b0, req1_valid = 1'b0;
    logic                req0_ready, req1_ready;
    logic [2:0]          req0_op = '0, req1_op = '0;
    logic [31:0]         req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic                rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err, busy;
    logic [31:0]         rsp_data;
    logic [TB_CNT_W-1:0] ops_done;
    logic [TB_CNT_W-1:0] exp_ops;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_share_arbiter #(.DATA_W(32), .OP_W(3), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_ops = '0;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic send(input bit id, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output bit ok);
        @(negedge clk);
        if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (id ? req1_ready : req0_ready) begin
                @(posedge clk); #1; ok = 1'b1; break;
            end
            @(negedge clk);
        end
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    // Poll on falling edges until a response is visible (bounded).
    task automatic wait_rsp(output bit got);
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (req0_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end
        tests_run++; if (req1_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready1: got %b want 0", req1_ready); end
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        tests_run++; if ({rsp_id, rsp_err, busy} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b want 000", {rsp_id, rsp_err, busy}); end
        tests_run++; if (rsp_data !== 32'h0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", rsp_data); end
        tests_run++; if (ops_done !== '0) begin tests_failed++; $display("FAIL reset_ops: got %0d want 0", ops_done); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        rsp_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'd5; req0_b = 32'd7;
        #1;
        tests_run++; if (req0_ready !== 1'b1) begin tests_failed++; $display("FAIL single_ready: got %b want 1", req0_ready); end
        @(posedge clk); #1; req0_valid = 1'b0;
        @(negedge clk);
        tests_run++; if ({busy, rsp_valid} !== 2'b10) begin tests_failed++; $display("FAIL single_exec: busy/valid got %b want 10", {busy, rsp_valid}); end
        @(negedge clk);
        tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL single_latency: rsp_valid got %b want 1", rsp_valid); end
        tests_run++; if (rsp_data !== 32'd12) begin tests_failed++; $display("FAIL single_data: got %h want %h", rsp_data, 32'd12); end
        tests_run++; if ({rsp_id, rsp_err} !== 2'b00) begin tests_failed++; $display("FAIL single_id_err: got %b want 00", {rsp_id, rsp_err}); end
        @(negedge clk);
        exp_ops = exp_ops + 1'b1;
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL single_clear: rsp_valid got %b want 0", rsp_valid); end
        tests_run++; if (ops_done !== exp_ops) begin tests_failed++; $display("FAIL single_ops: got %0d want %0d", ops_done, exp_ops); end
    endtask

    task automatic test_alternate();
        bit got;
        logic [31:0] want;
        do_reset();
        rsp_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 32'd3; req0_b = 32'd5;
        req1_valid = 1'b1; req1_op = 3'd4; req1_a = 32'hF0F0F0F0; req1_b = 32'hFF00FF00;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(got);
            want = (k % 2 == 0) ? 32'hFFFFFFFE : 32'h0FF00FF0;
            tests_run++;
            if (!got) begin tests_failed++; $display("FAIL alt_timeout: response %0d not seen", k); end
            else if (rsp_id !== k[0] || rsp_data !== want) begin
                tests_failed++;
                $display("FAIL alt_rsp%0d: id/data got %b/%h want %b/%h", k, rsp_id, rsp_data, k[0], want);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        exp_ops = exp_ops + 4'd4;
        tests_run++; if (ops_done !== exp_ops) begin tests_failed++; $display("FAIL alt_ops: got %0d want %0d", ops_done, exp_ops); end
    endtask

    task automatic test_illegal();
        bit ok, got;
        rsp_ready = 1'b1;
        send(1'b1, 3'd6, 32'h1234, 32'h5678, ok);
        wait_rsp(got);
        tests_run++; if (!(ok && got)) begin tests_failed++; $display("FAIL illegal_handshake: ok/got %b%b want 11", ok, got); end
        tests_run++; if ({rsp_id, rsp_err, rsp_data} !== {2'b11, 32'h0}) begin tests_failed++; $display("FAIL illegal_rsp: id/err/data got %b/%b/%h want 1/1/0", rsp_id, rsp_err, rsp_data); end
        @(posedge clk);
        send(1'b1, 3'd5, 32'h0, 32'h0, ok);
        wait_rsp(got);
        tests_run++; if (!(ok && got)) begin tests_failed++; $display("FAIL xnor_handshake: ok/got %b%b want 11", ok, got); end
        tests_run++; if ({rsp_id, rsp_err, rsp_data} !== {2'b10, 32'hFFFFFFFF}) begin tests_failed++; $display("FAIL xnor_rsp: id/err/data got %b/%b/%h want 1/0/ffffffff", rsp_id, rsp_err, rsp_data); end
        @(posedge clk); #1;
        exp_ops = exp_ops + 4'd2;
        tests_run++; if (ops_done !== exp_ops) begin tests_failed++; $display("FAIL illegal_ops: got %0d want %0d", ops_done, exp_ops); end
    endtask

    task automatic test_stall();
        bit ok, got;
        rsp_ready = 1'b0;
        send(1'b0, 3'd3, 32'h12340000, 32'h00005678, ok);
        wait_rsp(got);
        tests_run++; if (!(ok && got)) begin tests_failed++; $display("FAIL stall_handshake: ok/got %b%b want 11", ok, got); end
        req1_valid = 1'b1; req1_op = 3'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'h12345678 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: valid/id/data/busy got %b/%b/%h/%b want 1/0/12345678/1", i, rsp_valid, rsp_id, rsp_data, busy);
            end
            tests_run++;
            if ({req0_ready, req1_ready} !== 2'b00 || ops_done !== exp_ops) begin
                tests_failed++;
                $display("FAIL stall_block%0d: readys/ops got %b/%0d want 00/%0d", i, {req0_ready, req1_ready}, ops_done, exp_ops);
            end
        end
        rsp_ready = 1'b1; req1_valid = 1'b0;
        @(negedge clk);
        exp_ops = exp_ops + 1'b1;
        tests_run++; if (rsp_valid !== 1'b0 || ops_done !== exp_ops) begin tests_failed++; $display("FAIL stall_release: valid/ops got %b/%0d want 0/%0d", rsp_valid, ops_done, exp_ops); end
    endtask

    task automatic test_reset_exec();
        bit ok, got, seen;
        rsp_ready = 1'b1;
        send(1'b0, 3'd0, 32'd1, 32'd1, ok);
        tests_run++; if (!ok || busy !== 1'b1) begin tests_failed++; $display("FAIL rstexec_setup: ok/busy got %b/%b want 1/1", ok, busy); end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({rsp_valid, busy, rsp_id, rsp_err} !== 4'b0000 || rsp_data !== 32'h0 || ops_done !== '0) begin
            tests_failed++;
            $display("FAIL rstexec_async: valid/busy/id/err/data/ops got %b%b%b%b/%h/%0d want 0000/0/0", rsp_valid, busy, rsp_id, rsp_err, rsp_data, ops_done);
        end
        @(negedge clk); rst = 1'b0; exp_ops = '0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL rstexec_dropped: activity after reset got %b want 0", seen); end
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 32'hFF00FF00; req0_b = 32'h0FF00FF0;
        req1_valid = 1'b1; req1_op = 3'd0;
        #1;
        tests_run++; if ({req0_ready, req1_ready} !== 2'b10) begin tests_failed++; $display("FAIL rstexec_priority: readys got %b want 10", {req0_ready, req1_ready}); end
        @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(got);
        tests_run++; if (!got || rsp_id !== 1'b0 || rsp_data !== 32'h0F000F00) begin tests_failed++; $display("FAIL rstexec_rsp: got/id/data %b/%b/%h want 1/0/0f000f00", got, rsp_id, rsp_data); end
        @(posedge clk); #1;
        exp_ops = exp_ops + 1'b1;
        tests_run++; if (ops_done !== exp_ops) begin tests_failed++; $display("FAIL rstexec_ops: got %0d want %0d", ops_done, exp_ops); end
    endtask

    task automatic test_wrap();
        bit ok, got;
        do_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            send(1'b0, 3'd0, 32'hFFFFFFFF, 32'd1, ok);
            wait_rsp(got);
            if (k == 0) begin
                tests_run++; if (!got || rsp_data !== 32'h0) begin tests_failed++; $display("FAIL wrap_add_carry: got/data %b/%h want 1/0", got, rsp_data); end
            end
            @(posedge clk); #1;
            exp_ops = exp_ops + 1'b1;
            if (k == 14) begin
                tests_run++; if (ops_done !== 4'd15) begin tests_failed++; $display("FAIL wrap_max: got %0d want 15", ops_done); end
            end
        end
        tests_run++; if (ops_done !== exp_ops || ops_done !== 4'd0) begin tests_failed++; $display("FAIL wrap_zero: got %0d want 0", ops_done); end
        send(1'b1, 3'd1, 32'h0, 32'd1, ok);
        wait_rsp(got);
        tests_run++; if (!got || rsp_data !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL sub_borrow: got/data %b/%h want 1/ffffffff", got, rsp_data); end
        @(posedge clk);
    endtask

    initial begin
        exp_ops = '0;
        test_reset();
        test_single();
        test_alternate();
        test_illegal();
        test_stall();
        test_reset_exec();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit logic unit (sum, difference, and, or, xor, xnor) between two requesters, typically the two FIFO read sides.
- Arbitrates round-robin and accepts one operation at a time through valid/ready.
- Registers the selected result and returns it on a single tagged response channel with valid/ready backpressure.
- Sits between the FIFO outputs and the downstream result sink/FIFO.

Parameters:
- DATA_W, 32, operand and result width
- OP_W, 3, opcode width
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 operation valid
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  OP_W  requester 0 opcode
- req0_a  in  DATA_W  requester 0 operand a
- req0_b  in  DATA_W  requester 0 operand b
- req1_valid, req1_ready, req1_op, req1_a, req1_b  (same as requester 0, for requester 1)
- rsp_valid  out  1  result valid
- rsp_ready  in  1  downstream accepts result
- rsp_id  out  1  requester index that owns the result
- rsp_data  out  DATA_W  result
- rsp_err  out  1  illegal opcode flag for this result
- busy  out  1  high whenever state != IDLE
- ops_done  out  CNT_W  count of completed response handshakes, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values: state IDLE; rsp_valid, rsp_id, rsp_data, rsp_err, busy, ops_done all 0; req0_ready and req1_ready 0. last_grant resets to 1, so requester 0 has priority first.
- Reset asserted mid-operation drops the in-flight operation silently; no response is produced.
- FSM has three states:
  - IDLE:
    - req0_ready = !req1_valid | (last_grant==1); req1_ready = !req0_valid | (last_grant==0). Both readys are low outside IDLE.
    - Handshake on reqN (valid & ready): latch op/a/b, id=N, set last_grant=N, go to EXEC.
    - Both valid: only the non-last_grant requester is ready.
    - At most one handshake per cycle.
  - EXEC: one cycle; the latched operands drive the logic unit. Register rsp_data by opcode:
    - 0 a+b
    - 1 a-b
    - 2 a&b
    - 3 a|b
    - 4 a^b
    - 5 a~^b
    - 6,7: rsp_data=0, rsp_err=1 (rsp_err=0 otherwise)
    - Go to RESP.
  - RESP:
    - rsp_valid=1. rsp_id, rsp_data and rsp_err are held stable until rsp_ready.
    - On handshake: rsp_valid clears next cycle, ops_done increments, go to IDLE.
- Latency: request accepted in cycle N, rsp_valid high in cycle N+2.
- Peak throughput: one operation per 3 cycles (4 when a response stalls for one cycle).
- Arithmetic: add/sub are modulo 2^DATA_W; carry and borrow are discarded. Example: 0xFFFFFFFF+1=0, 0-1=0xFFFFFFFF.
- A valid requester is never starved. After granting N, the other requester wins the next contention.
- Requester payload may change while valid & !ready; only the payload at the handshake is used.
- ops_done wraps from 0xFFFF to 0 with no flag.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_XNOR=5.
  - State encoding: IDLE=0, EXEC=1, RESP=2.
  - Default widths.
- Sub-module rr_arb2: the two-input round-robin grant with last_grant register, producing req0_ready/req1_ready.
- The logic unit is instantiated unchanged; opcode-select mux and result register live in this block.

Test Plan:
- Reset, then req0 op=0 a=5 b=7 with rsp_ready=1 -> req0_ready same cycle; rsp_valid two cycles later; rsp_data=12, rsp_id=0, rsp_err=0; ops_done=1.
- Both requesters hold valid continuously, req0 op=1 a=3 b=5 and req1 op=4 a=0xF0F0F0F0 b=0xFF00FF00 -> responses alternate id 0,1,0,1 with data 0xFFFFFFFE and 0x0FF00FF0.
- req1 op=6 -> rsp_data=0, rsp_err=1. Next req1 op=5 a=0 b=0 -> rsp_data=0xFFFFFFFF, rsp_err=0.
- rsp_ready held low 5 cycles in RESP -> rsp_valid/id/data stable; both req readys 0; busy=1; nothing accepted until the handshake.
- rst pulsed asynchronously while in EXEC -> all outputs 0 immediately; no response after release; ops_done=0; next contention grants req0 first.
- 65536 completed operations -> ops_done reads 0.
